// File: rtl/shift_add_mult16_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM encodings and iteration limits.
// Optional feature macro MULT16_SIGNED_EN (two's complement operands) is consumed by the top.
package shift_add_mult16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    typedef logic [1:0]       state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_NEG  = 2'd3;

    localparam cnt_t ITER_LAST = 5'd15;

    // 16'h8000 maps to itself, which is the correct unsigned magnitude of -32768.
    function automatic logic [WIDTH-1:0] mag16(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/shift_add_mult16_if.sv
// Start/busy/done handshake plus operand and product buses between control unit and multiplier.
interface shift_add_mult16_if;
    import shift_add_mult16_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/shift_add_mult16_adder16.sv
// ADDER16: purely combinational 16-bit adder with carry-in and carry-out.
module shift_add_mult16_adder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o
);

    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'b0, c_i};

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential 16x16->32 shift-and-add multiplier, one partial product per clock via ADDER16.
// Build with MULT16_SIGNED_EN for two's complement operands (adds a one-cycle NEG state).
module shift_add_mult16
    import shift_add_mult16_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    shift_add_mult16_if.slave bus
);

    state_t             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] p_q, p_d;
`ifdef MULT16_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH:0]   acc_full;
    logic [2*WIDTH-1:0] acc_shift;

    assign add_b = lo_q[0] ? mcand_q : '0;

    shift_add_mult16_adder16 u_add (
        .a_i   (hi_q),
        .b_i   (add_b),
        .c_i   (1'b0),
        .sum_o (add_sum),
        .c_o   (add_cout)
    );

    // The carry-out must ride into HI[15]; dropping it breaks FFFF*FFFF.
    assign acc_full  = {add_cout, add_sum, lo_q};
    assign acc_shift = acc_full[2*WIDTH:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
`ifdef MULT16_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
`ifdef MULT16_SIGNED_EN
                    mcand_d = mag16(bus.a);
                    lo_d    = mag16(bus.b);
                    neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
                    mcand_d = bus.a;
                    lo_d    = bus.b;
`endif
                end
            end
            ST_RUN: begin
                {hi_d, lo_d} = acc_shift;
                cnt_d        = cnt_q + 5'd1;
                if (cnt_q == ITER_LAST) begin
`ifdef MULT16_SIGNED_EN
                    state_d = ST_NEG;
`else
                    state_d = ST_DONE;
                    p_d     = acc_shift;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_NEG: begin
`ifdef MULT16_SIGNED_EN
                state_d = ST_DONE;
                p_d     = neg_q ? (~{hi_q, lo_q} + 32'd1) : {hi_q, lo_q};
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
`ifdef MULT16_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
`ifdef MULT16_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

`ifdef MULT16_SIGNED_EN
    assign bus.busy = (state_q == ST_RUN) || (state_q == ST_NEG);
`else
    assign bus.busy = (state_q == ST_RUN);
`endif
    assign bus.done = (state_q == ST_DONE);
    assign bus.p    = p_q;

endmodule
